// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   lsu_funct3_e : RISC-V load/store funct3 codes
//   lsu_state_e  : load_store_unit FSM states
//   helpers      : access-size decode, legality, alignment checks
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MERGE,
        ST_RESP
    } lsu_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Access size is encoded in the low two funct3 bits.
    function automatic logic [1:0] lsu_size(input logic [2:0] f3);
        return f3[1:0];
    endfunction

    // Unsigned loads only; an unsigned store encoding is illegal.
    function automatic logic lsu_illegal(input logic [2:0] f3, input logic we);
        logic bad;
        case (f3)
            LSU_B, LSU_H, LSU_W: bad = 1'b0;
            LSU_BU, LSU_HU:      bad = we;
            default:             bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        return ((lsu_size(f3) == SZ_HALF) && lane[0]) ||
               ((lsu_size(f3) == SZ_WORD) && (lane != 2'b00));
    endfunction

    // Forces the lane to natural alignment for the access size.
    function automatic logic [1:0] lsu_align_lane(input logic [2:0] f3, input logic [1:0] lane);
        logic [1:0] res;
        case (lsu_size(f3))
            SZ_HALF: res = {lane[1], 1'b0};
            SZ_WORD: res = 2'b00;
            default: res = lane;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load formatting.
//   i_word   : 32-bit RAM word
//   i_lane   : byte lane of the access (addr[1:0])
//   i_funct3 : load funct3 (size in [1:0], zero-extend in [2])
//   o_data   : selected, sign/zero-extended result; words pass through
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    always_comb begin
        byte_sel = i_word[{i_lane, 3'b000} +: 8];
        half_sel = i_lane[1] ? i_word[31:16] : i_word[15:0];
        sext     = ~i_funct3[2];
        case (lsu_size(i_funct3))
            SZ_BYTE: o_data = {{24{byte_sel[7] & sext}}, byte_sel};
            SZ_HALF: o_data = {{16{half_sel[15] & sext}}, half_sel};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: data-side access stage driving RAM port A.
//   Request : i_req_valid/o_req_ready, i_req_we, i_req_funct3, i_req_addr, i_req_wdata
//   Response: o_rsp_valid (1-cycle pulse), o_rsp_rdata, o_rsp_fault
//   RAM     : o_ram_addr (word), o_ram_data, o_ram_we, i_ram_data (1-cycle latency)
// Sub-word stores are done as read-modify-write (not atomic against port B).
// LSU_MISALIGN_TRAP_EN: defined -> misaligned H/W fault; undefined -> low
// address bits are forced to natural alignment and the access proceeds.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [2:0]            i_req_funct3,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [31:0]           o_rsp_rdata,
    output logic                  o_rsp_fault,
    output logic [ADDR_WIDTH-3:0] o_ram_addr,
    output logic [31:0]           o_ram_data,
    output logic                  o_ram_we,
    input  logic [31:0]           i_ram_data
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("load_store_unit: DATA_WIDTH must be 32");
    end

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-3:0] waddr_q, waddr_d;
    logic [1:0]            lane_q, lane_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  fault_q, fault_d;

    logic                  req_fault;
    logic [1:0]            req_lane;
    logic [31:0]           load_word;
    logic [31:0]           merge_word;
    logic                  ram_we;
    logic [ADDR_WIDTH-3:0] ram_addr;
    logic [31:0]           ram_data;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_fault = lsu_illegal(i_req_funct3, i_req_we) ||
                       lsu_misaligned(i_req_funct3, i_req_addr[1:0]);
    assign req_lane  = i_req_addr[1:0];
`else
    assign req_fault = lsu_illegal(i_req_funct3, i_req_we);
    assign req_lane  = lsu_align_lane(i_req_funct3, i_req_addr[1:0]);
`endif

    lsu_load_align u_load_align (
        .i_word   (i_ram_data),
        .i_lane   (lane_q),
        .i_funct3 (funct3_q),
        .o_data   (load_word)
    );

    // Replace the target byte/half of the word read back at the accept edge.
    always_comb begin
        merge_word = i_ram_data;
        if (lsu_size(funct3_q) == SZ_HALF) begin
            if (lane_q[1]) merge_word[31:16] = wdata_q;
            else           merge_word[15:0]  = wdata_q;
        end else begin
            merge_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        lane_d   = lane_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        ram_we   = 1'b0;
        ram_addr = waddr_q;
        ram_data = '0;
        case (state_q)
            ST_IDLE: begin
                // RAM is driven straight from the request so reads and
                // full-word writes happen on the accept edge itself.
                ram_addr = i_req_addr[ADDR_WIDTH-1:2];
                ram_data = i_req_wdata;
                ram_we   = i_req_valid && i_req_we &&
                           (i_req_funct3 == LSU_W) && !req_fault;
                if (i_req_valid) begin
                    waddr_d  = i_req_addr[ADDR_WIDTH-1:2];
                    lane_d   = req_lane;
                    funct3_d = i_req_funct3;
                    wdata_d  = i_req_wdata[15:0];
                    fault_d  = req_fault;
                    rdata_d  = '0;
                    if (req_fault)                    state_d = ST_RESP;
                    else if (!i_req_we)               state_d = ST_LOAD;
                    else if (i_req_funct3 == LSU_W)   state_d = ST_RESP;
                    else                              state_d = ST_MERGE;
                end
            end
            ST_LOAD: begin
                rdata_d = load_word;
                state_d = ST_RESP;
            end
            ST_MERGE: begin
                ram_we   = 1'b1;
                ram_data = merge_word;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            waddr_q  <= '0;
            lane_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            waddr_q  <= waddr_d;
            lane_q   <= lane_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    // RAM-facing outputs are gated by reset so an in-flight MERGE write
    // cannot land while reset is asserted.
    assign o_req_ready = i_rst_n && (state_q == ST_IDLE);
    assign o_rsp_valid = (state_q == ST_RESP);
    assign o_rsp_rdata = o_rsp_valid ? rdata_q : '0;
    assign o_rsp_fault = o_rsp_valid && fault_q;
    assign o_ram_we    = i_rst_n && ram_we;
    assign o_ram_addr  = i_rst_n ? ram_addr : '0;
    assign o_ram_data  = i_rst_n ? ram_data : '0;

endmodule
